// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// vram_arbiter_if: requester, debug and memory-port signal bundle
// Rev 1.0
// ------------------------------------------------------------------
interface vram_arbiter_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 9,
  parameter int STALL_W = 16
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic              drw_req;
  logic              drw_we;
  logic [ADDR_W-1:0] drw_addr;
  logic [DATA_W-1:0] drw_wdata;
  logic              drw_ack;
  logic [DATA_W-1:0] drw_rdata;
  logic              drw_rvalid;
  logic              stall_clr;
  logic [STALL_W-1:0] stall_cnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, drw_req, drw_we, drw_addr, drw_wdata,
           stall_clr, mem_rdata,
    output vga_rdata, vga_rvalid, drw_ack, drw_rdata, drw_rvalid,
           stall_cnt, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, drw_req, drw_we, drw_addr, drw_wdata,
           stall_clr, mem_rdata,
    input  vga_rdata, vga_rvalid, drw_ack, drw_rdata, drw_rvalid,
           stall_cnt, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// vram_arbiter: fixed-priority VGA/drawer arbiter for a 1-port VRAM
// Rev 1.0
// ------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 9,
  parameter int MEM_LAT = 1,
  parameter int STALL_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  bus
);
  localparam logic [1:0] c_TAG_NONE = 2'b00;
  localparam logic [1:0] c_TAG_VGA  = 2'b01;
  localparam logic [1:0] c_TAG_DRW  = 2'b10;

  logic               r_buf_valid;
  logic [ADDR_W-1:0]  r_buf_addr;
  logic [DATA_W-1:0]  r_buf_data;
  logic [1:0]         r_tag [MEM_LAT];
  logic [DATA_W-1:0]  r_vga_rdata;
  logic               r_vga_rvalid;
  logic [DATA_W-1:0]  r_drw_rdata;
  logic               r_drw_rvalid;
  logic [STALL_W-1:0] r_stall;

  logic w_vga_issue;
  logic w_drain;
  logic w_drd_issue;
  logic w_wr_accept;
  logic w_ack;
  logic [1:0] w_ret_tag;

  // Write acceptance ignores VGA traffic; it only needs an empty buffer,
  // which also rules out accepting in the cycle the buffer drains.
  assign w_vga_issue = bus.vga_req;
  assign w_drain     = !bus.vga_req && r_buf_valid;
  assign w_drd_issue = !bus.vga_req && !r_buf_valid && bus.drw_req && !bus.drw_we;
  assign w_wr_accept = bus.drw_req && bus.drw_we && !r_buf_valid;
  assign w_ack       = w_drd_issue || w_wr_accept;
  assign w_ret_tag   = r_tag[MEM_LAT-1];

  assign bus.drw_ack    = w_ack;
  assign bus.vga_rdata  = r_vga_rdata;
  assign bus.vga_rvalid = r_vga_rvalid;
  assign bus.drw_rdata  = r_drw_rdata;
  assign bus.drw_rvalid = r_drw_rvalid;
  assign bus.stall_cnt  = r_stall;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_vga_issue) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.vga_addr;
    end else if (w_drain) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = r_buf_addr;
      bus.mem_wdata = r_buf_data;
    end else if (w_drd_issue) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.drw_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
    end else if (w_drain) begin
      r_buf_valid <= 1'b0;
    end else if (w_wr_accept) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= bus.drw_addr;
      r_buf_data  <= bus.drw_wdata;
    end
  end

  // Tag stage k holds the owner of the read issued k+1 cycles ago, so the
  // last stage lines up with the cycle mem_rdata is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LAT; i++) r_tag[i] <= c_TAG_NONE;
    end else begin
      r_tag[0] <= w_vga_issue ? c_TAG_VGA : (w_drd_issue ? c_TAG_DRW : c_TAG_NONE);
      for (int i = 1; i < MEM_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vga_rdata  <= '0;
      r_vga_rvalid <= 1'b0;
      r_drw_rdata  <= '0;
      r_drw_rvalid <= 1'b0;
    end else begin
      r_vga_rvalid <= (w_ret_tag == c_TAG_VGA);
      r_drw_rvalid <= (w_ret_tag == c_TAG_DRW);
      if (w_ret_tag == c_TAG_VGA) r_vga_rdata <= bus.mem_rdata;
      if (w_ret_tag == c_TAG_DRW) r_drw_rdata <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (bus.stall_clr) begin
      r_stall <= '0;
    end else if (bus.drw_req && !w_ack && (r_stall != {STALL_W{1'b1}})) begin
      r_stall <= r_stall + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_vram_arbiter: directed tables plus randomized traffic vs. model
// Rev 1.0
// ------------------------------------------------------------------
module tb_vram_arbiter;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 9;
  localparam int MEM_LAT = 2;
  localparam int STALL_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STALL_W(STALL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Synchronous RAM: unwritten words read back as their own address.
  logic [DATA_W-1:0] vmem   [256];
  logic              vmem_w [256];
  logic [DATA_W-1:0] pipe_d [MEM_LAT];
  logic              pipe_v [MEM_LAT];
  logic [DATA_W-1:0] junk;
  logic [7:0]        ma;
  assign ma = bus.mem_addr[7:0];
  assign bus.mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : junk;

  always @(posedge clk) begin
    junk <= DATA_W'($urandom);
    if (!rst) begin
      for (int i = 0; i < 256; i++) vmem_w[i] <= 1'b0;
    end else if (bus.mem_en && bus.mem_we) begin
      vmem[ma]   <= bus.mem_wdata;
      vmem_w[ma] <= 1'b1;
    end
    pipe_v[0] <= bus.mem_en && !bus.mem_we;
    pipe_d[0] <= vmem_w[ma] ? vmem[ma] : DATA_W'(ma);
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: pending returns as a due-cycle queue, plus a shadow RAM.
  typedef struct {
    int               due;
    bit               is_drw;
    logic [DATA_W-1:0] data;
  } ret_t;
  ret_t retq[$];
  logic [DATA_W-1:0] mref [256];
  bit                m_buf_v;
  logic [ADDR_W-1:0] m_buf_a;
  logic [DATA_W-1:0] m_buf_d;
  int                m_stall;
  logic [DATA_W-1:0] e_vga_rd, e_drw_rd;
  bit d_vga, d_drain, d_drd, d_wacc, d_ack, d_clr, d_req;
  logic [ADDR_W-1:0] d_vaddr, d_daddr;
  logic [DATA_W-1:0] d_wdata;

  task automatic model_reset();
    retq.delete();
    for (int i = 0; i < 256; i++) mref[i] = DATA_W'(i);
    m_buf_v  = 0;
    m_stall  = 0;
    e_vga_rd = '0;
    e_drw_rd = '0;
  endtask

  task automatic check_cycle();
    bit ev, ed;
    logic [31:0] ea, ew;
    ret_t r;
    @(negedge clk);
    d_vga   = bus.vga_req;
    d_req   = bus.drw_req;
    d_clr   = bus.stall_clr;
    d_vaddr = bus.vga_addr;
    d_daddr = bus.drw_addr;
    d_wdata = bus.drw_wdata;
    d_drain = !d_vga && m_buf_v;
    d_drd   = !d_vga && !m_buf_v && d_req && !bus.drw_we;
    d_wacc  = d_req && bus.drw_we && !m_buf_v;
    d_ack   = d_drd || d_wacc;
    ea = d_vga ? 32'(d_vaddr) : d_drain ? 32'(m_buf_a) : d_drd ? 32'(d_daddr) : 32'd0;
    ew = d_drain ? 32'(m_buf_d) : 32'd0;
    ev = 0;
    ed = 0;
    while (retq.size() > 0 && retq[0].due == cyc) begin
      r = retq.pop_front();
      if (r.is_drw) begin ed = 1; e_drw_rd = r.data; end
      else          begin ev = 1; e_vga_rd = r.data; end
    end
    chk("drw_ack",    32'(bus.drw_ack),    32'(d_ack));
    chk("mem_en",     32'(bus.mem_en),     32'(d_vga || d_drain || d_drd));
    chk("mem_we",     32'(bus.mem_we),     32'(d_drain));
    chk("mem_addr",   32'(bus.mem_addr),   ea);
    chk("mem_wdata",  32'(bus.mem_wdata),  ew);
    chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(ev));
    chk("vga_rdata",  32'(bus.vga_rdata),  32'(e_vga_rd));
    chk("drw_rvalid", 32'(bus.drw_rvalid), 32'(ed));
    chk("drw_rdata",  32'(bus.drw_rdata),  32'(e_drw_rd));
    chk("stall_cnt",  32'(bus.stall_cnt),  32'(m_stall));
  endtask

  task automatic commit_cycle();
    @(posedge clk);
    if (d_vga) retq.push_back('{cyc + MEM_LAT + 1, 1'b0, mref[d_vaddr[7:0]]});
    if (d_drd) retq.push_back('{cyc + MEM_LAT + 1, 1'b1, mref[d_daddr[7:0]]});
    if (d_drain) begin
      mref[m_buf_a[7:0]] = m_buf_d;
      m_buf_v = 0;
    end
    if (d_wacc) begin
      m_buf_v = 1;
      m_buf_a = d_daddr;
      m_buf_d = d_wdata;
    end
    if (d_clr) m_stall = 0;
    else if (d_req && !d_ack && m_stall < (1 << STALL_W) - 1) m_stall++;
    cyc++;
    #1;
  endtask

  task automatic step();
    check_cycle();
    commit_cycle();
  endtask

  task automatic idle_inputs();
    bus.vga_req   = 0;
    bus.vga_addr  = '0;
    bus.drw_req   = 0;
    bus.drw_we    = 0;
    bus.drw_addr  = '0;
    bus.drw_wdata = '0;
    bus.stall_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
    chk("rst_drw_rvalid", 32'(bus.drw_rvalid), 32'd0);
    chk("rst_vga_rdata",  32'(bus.vga_rdata),  32'd0);
    chk("rst_drw_rdata",  32'(bus.drw_rdata),  32'd0);
    chk("rst_stall_cnt",  32'(bus.stall_cnt),  32'd0);
    chk("rst_mem_en",     32'(bus.mem_en),     32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              drw_req;
    logic              drw_we;
    logic [ADDR_W-1:0] drw_addr;
    logic [DATA_W-1:0] drw_wdata;
    logic              ack;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STALL_W-1:0] stall;
  } vec_t;
  vec_t tab [7];

  initial begin
    // Posted write under VGA contention: accepted at once, drained in cycle 5.
    tab[0] = '{1'b1, 16'h0020, 1'b1, 1'b1, 16'h0040, 9'h1FF, 1'b1, 1'b1, 1'b0, 16'h0020, 9'h000, 4'h0};
    for (int i = 1; i < 5; i++)
      tab[i] = '{1'b1, 16'(16'h0020 + i), 1'b0, 1'b0, 16'h0040, 9'h1FF, 1'b0, 1'b1, 1'b0, 16'(16'h0020 + i), 9'h000, 4'h0};
    tab[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 9'h1FF, 1'b0, 1'b1, 1'b1, 16'h0040, 9'h1FF, 4'h0};
    tab[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 9'h1FF, 1'b0, 1'b0, 1'b0, 16'h0000, 9'h000, 4'h0};

    idle_inputs();
    do_reset();

    // Reset one cycle after a VGA read: its return must never appear.
    bus.vga_req  = 1;
    bus.vga_addr = 16'h0005;
    step();
    do_reset();
    repeat (5) step();

    // VGA streaming of addresses 0..7.
    for (int i = 0; i < 8; i++) begin
      bus.vga_req  = 1;
      bus.vga_addr = 16'(i);
      step();
    end
    idle_inputs();
    for (int i = 0; i < MEM_LAT + 1; i++) step();
    chk("stream_last_data", 32'(bus.vga_rdata), 32'd7);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      bus.vga_req   = tab[i].vga_req;
      bus.vga_addr  = tab[i].vga_addr;
      bus.drw_req   = tab[i].drw_req;
      bus.drw_we    = tab[i].drw_we;
      bus.drw_addr  = tab[i].drw_addr;
      bus.drw_wdata = tab[i].drw_wdata;
      check_cycle();
      chk("tab_ack",   32'(bus.drw_ack),   32'(tab[i].ack));
      chk("tab_en",    32'(bus.mem_en),    32'(tab[i].en));
      chk("tab_we",    32'(bus.mem_we),    32'(tab[i].we));
      chk("tab_addr",  32'(bus.mem_addr),  32'(tab[i].addr));
      chk("tab_wdata", 32'(bus.mem_wdata), 32'(tab[i].wdata));
      chk("tab_stall", 32'(bus.stall_cnt), 32'(tab[i].stall));
      commit_cycle();
    end
    idle_inputs();
    repeat (3) step();

    // Read-after-write: read waits out the drain, then returns the new data.
    bus.drw_req = 1; bus.drw_we = 1; bus.drw_addr = 16'h0010; bus.drw_wdata = 9'h0AA;
    check_cycle();
    chk("raw_wr_ack", 32'(bus.drw_ack), 32'd1);
    commit_cycle();
    bus.drw_we = 0;
    check_cycle();
    chk("raw_drain_noack", 32'(bus.drw_ack), 32'd0);
    chk("raw_drain_we",    32'(bus.mem_we),  32'd1);
    commit_cycle();
    check_cycle();
    chk("raw_rd_ack", 32'(bus.drw_ack), 32'd1);
    commit_cycle();
    bus.drw_req = 0;
    for (int i = 0; i < MEM_LAT; i++) step();
    check_cycle();
    chk("raw_rvalid", 32'(bus.drw_rvalid), 32'd1);
    chk("raw_rdata",  32'(bus.drw_rdata),  32'h0AA);
    commit_cycle();

    // Starvation: stall_cnt saturates, then clear wins over increment.
    bus.vga_req = 1; bus.vga_addr = 16'h0001;
    bus.drw_req = 1; bus.drw_we = 0; bus.drw_addr = 16'h0003;
    repeat (20) step();
    chk("sat_stall", 32'(bus.stall_cnt), 32'hF);
    bus.stall_clr = 1;
    step();
    chk("clr_stall", 32'(bus.stall_cnt), 32'd0);
    bus.stall_clr = 0;
    step();
    chk("restart_stall", 32'(bus.stall_cnt), 32'd1);
    bus.vga_req = 0;
    check_cycle();
    chk("unstarve_ack", 32'(bus.drw_ack), 32'd1);
    commit_cycle();
    idle_inputs();
    repeat (4) step();

    // Randomized mixed traffic; drawer obeys hold-until-ack.
    for (int n = 0; n < 800; n++) begin
      bus.vga_req  = ($urandom_range(99) < 55);
      bus.vga_addr = 16'($urandom_range(255));
      if (!bus.drw_req && $urandom_range(2) == 0) begin
        bus.drw_req   = 1;
        bus.drw_we    = 1'($urandom_range(1));
        bus.drw_addr  = 16'($urandom_range(15));
        bus.drw_wdata = DATA_W'($urandom);
      end
      bus.stall_clr = ($urandom_range(39) == 0);
      step();
      if (d_ack) bus.drw_req = 0;
    end
    idle_inputs();
    repeat (MEM_LAT + 3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Arbitrates a single-port synchronous video RAM between two requesters:
  - the VGA scan-out reader, which has hard real-time priority;
  - a drawing requester, such as the key-highlight renderer.
- Drawer writes go through a one-entry posted-write buffer.
- Read data returns after a fixed pipeline latency.
- A saturating stall counter is exported for the 7-segment debug digits.

Parameters:
ADDR_W, 16, video memory address width
DATA_W, 9, pixel width (3:3:3 RGB)
MEM_LAT, 1, memory read latency in cycles, legal range 1..4
STALL_W, 16, stall counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
vga_req  in  1  VGA read request; single-cycle, never stalled
vga_addr  in  ADDR_W  VGA read address
vga_rdata  out  DATA_W  VGA read data
vga_rvalid  out  1  VGA read data valid pulse
drw_req  in  1  drawer request; held until drw_ack
drw_we  in  1  1 = write, 0 = read
drw_addr  in  ADDR_W  drawer address
drw_wdata  in  DATA_W  drawer write data
drw_ack  out  1  drawer request accepted (combinational, same cycle)
drw_rdata  out  DATA_W  drawer read data
drw_rvalid  out  1  drawer read data valid pulse
stall_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  STALL_W  cycles drawer waited (drw_req & !drw_ack), saturating
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after issue

Behaviour:
- Reset (rst=0, async):
  - write buffer empty; tag pipeline cleared; stall_cnt=0.
  - vga_rvalid, drw_rvalid, vga_rdata and drw_rdata are all 0.
  - In-flight reads are discarded: no rvalid ever appears for a read issued before reset.
- Memory port outputs are combinational from the cycle's arbitration decision. Idle cycle: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Each cycle exactly one slot is granted, in fixed priority order:
  - 1) vga_req=1: VGA read issued; mem_en=1, mem_we=0, mem_addr=vga_addr.
  - 2) else buffer valid: drain; mem_en=1, mem_we=1, buffer address/data driven; buffer cleared at the clock edge.
  - 3) else drw_req=1 and drw_we=0: drawer read issued; drw_ack=1.
  - 4) else idle.
- Drawer write acceptance:
  - Condition: drw_req=1, drw_we=1 and buffer empty at cycle start. Independent of vga_req.
  - drw_ack=1 that cycle; address and data are captured into the buffer at the edge.
  - A write is never accepted in the same cycle the buffer drains. Back-to-back drawer writes therefore take at least 2 cycles each.
- Drawer reads are issued only when the buffer is empty. This guarantees read-after-write ordering without forwarding.
- Drawer must hold drw_req, drw_we, drw_addr and drw_wdata stable until drw_ack. Changes before ack are undefined.
- Read return (read issued in cycle N):
  - mem_rdata is sampled in cycle N+MEM_LAT.
  - The matching rdata and rvalid are registered and visible during cycle N+MEM_LAT+1, as a 1-cycle pulse.
  - A MEM_LAT-deep tag shift register (vga/drw/none) routes each return.
  - rdata holds its last value when rvalid=0.
- Throughput: back-to-back VGA reads every cycle yield rvalid every cycle with no bubbles.
- stall_cnt:
  - Increments each cycle drw_req=1 & drw_ack=0.
  - Saturates at all-ones.
  - stall_clr=1 sets it to 0 at the next edge; clear has priority over increment.
- Continuous vga_req starves the drawer indefinitely. This is by design; stall_cnt exposes it.

Test Plan:
- Reset mid-read (MEM_LAT=2): VGA read at cycle 0, rst low at cycle 1 → no vga_rvalid afterwards; all outputs 0.
- VGA streaming: vga_req=1 with addr 0..7 on consecutive cycles, mem returning data = addr → vga_rvalid high on cycles MEM_LAT+1 .. MEM_LAT+8, vga_rdata 0..7 in order.
- Posted write under contention: vga_req=1 for 5 cycles, drawer writes 0x1FF to 0x0040 →
  - drw_ack in cycle 0; stall_cnt stays 0;
  - mem_we pulses in cycle 5 with addr 0x0040, wdata 0x1FF.
- RAW ordering: drawer write 0x0AA @0x10, then read @0x10 →
  - read is acked only after the drain cycle;
  - drw_rdata = 0x0AA with drw_rvalid MEM_LAT+1 cycles after the read ack.
- Starvation and saturation (STALL_W=4): drw_req held with vga_req=1 for 20 cycles →
  - stall_cnt saturates at 0xF;
  - stall_clr=1 → 0 next cycle;
  - simultaneous clr and stall → 0.
- Mixed traffic: alternate vga_req with pending drawer write + read → grant order per priority; tags route data to the correct port with no swap.
